// File: rtl/hotspot_stencil_window.sv
// Raster-order 5-point stencil window generator {c,n,s,e,w} with edge clamping.
// Define HOTSPOT_STENCIL_FRAME_COUNT_EN to build the completed-frame counter.
module hotspot_stencil_window #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_COLS   = 1024,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                    aclk,
  input  logic                    axi_reset,
  input  logic [DATA_WIDTH-1:0]   s_axis_temp_data,
  input  logic                    s_axis_temp_valid,
  output logic                    s_axis_temp_ready,
  output logic [5*DATA_WIDTH-1:0] m_axis_window_data,
  output logic                    m_axis_window_valid,
  input  logic                    m_axis_window_ready,
  output logic                    m_axis_window_last,
  input  logic [DIM_WIDTH-1:0]    cols,
  input  logic [DIM_WIDTH-1:0]    rows,
  output logic                    cfg_error,
  output logic [31:0]             frame_count
);

  localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [DIM_WIDTH-1:0]    numCols_q, numCols_d, numRows_q, numRows_d;
  logic [DIM_WIDTH-1:0]    colCnt_q, colCnt_d, rowCnt_q, rowCnt_d;
  logic                    cfgErr_q, cfgErr_d;
  logic [DATA_WIDTH-1:0]   westPrev_q, westPrev_d;
  logic [5*DATA_WIDTH-1:0] winData_q, winData_d;
  logic                    winValid_q, winValid_d, winLast_q, winLast_d;

  // lineA holds the row above the input row (centre row), lineB the row above that.
  logic [DATA_WIDTH-1:0]   lineA [MAX_COLS];
  logic [DATA_WIDTH-1:0]   lineB [MAX_COLS];

  logic [AW-1:0]           addr, addrEast;
  logic [DATA_WIDTH-1:0]   ctrVal, northVal, southVal, eastVal, westVal;
  logic                    cfgLegal, colLast, canTake, load, lineWrite;

  assign addr     = colCnt_q[AW-1:0];
  assign addrEast = addr + 1'b1;
  assign colLast  = (colCnt_q == numCols_q - 1'b1);
  assign cfgLegal = (cols >= DIM_WIDTH'(2)) && (32'(cols) <= 32'(MAX_COLS)) &&
                    (rows >= DIM_WIDTH'(2));

  // Clamped taps never reach the stale line-buffer words of a previous frame.
  assign ctrVal   = lineA[addr];
  assign northVal = (rowCnt_q == DIM_WIDTH'(1)) ? ctrVal : lineB[addr];
  assign southVal = (state_q == FLUSH) ? ctrVal : s_axis_temp_data;
  assign eastVal  = colLast ? ctrVal : lineA[addrEast];
  assign westVal  = (colCnt_q == '0) ? ctrVal : westPrev_q;

  always_comb begin
    state_d           = state_q;
    numCols_d         = numCols_q;
    numRows_d         = numRows_q;
    colCnt_d          = colCnt_q;
    rowCnt_d          = rowCnt_q;
    cfgErr_d          = cfgErr_q;
    westPrev_d        = westPrev_q;
    winData_d         = winData_q;
    winValid_d        = winValid_q;
    winLast_d         = winLast_q;
    s_axis_temp_ready = 1'b0;
    load              = 1'b0;
    lineWrite         = 1'b0;
    canTake           = ~winValid_q | m_axis_window_ready;
    case (state_q)
      IDLE: begin
        if (!cfgErr_q) begin
          numCols_d = cols;
          numRows_d = rows;
          colCnt_d  = '0;
          rowCnt_d  = '0;
          if (cfgLegal) state_d = FILL;
          else          cfgErr_d = 1'b1;
        end
      end
      FILL: begin
        s_axis_temp_ready = 1'b1;
        if (s_axis_temp_valid) begin
          lineWrite = 1'b1;
          if (colLast) begin
            colCnt_d = '0;
            rowCnt_d = DIM_WIDTH'(1);
            state_d  = RUN;
          end else begin
            colCnt_d = colCnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        s_axis_temp_ready = canTake;
        if (s_axis_temp_valid && canTake) begin
          lineWrite = 1'b1;
          load      = 1'b1;
          if (colLast) begin
            colCnt_d = '0;
            if (rowCnt_q == numRows_q - 1'b1) begin
              rowCnt_d = numRows_q;
              state_d  = FLUSH;
            end else begin
              rowCnt_d = rowCnt_q + 1'b1;
            end
          end else begin
            colCnt_d = colCnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (winValid_q && winLast_q) begin
          if (m_axis_window_ready) state_d = IDLE;
        end else if (canTake) begin
          load     = 1'b1;
          colCnt_d = colCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      winData_d  = {ctrVal, northVal, southVal, eastVal, westVal};
      winValid_d = 1'b1;
      winLast_d  = (state_q == FLUSH) && colLast;
      westPrev_d = ctrVal;
    end else if (m_axis_window_ready) begin
      winValid_d = 1'b0;
      winLast_d  = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (axi_reset) begin
      state_q    <= IDLE;
      numCols_q  <= '0;
      numRows_q  <= '0;
      colCnt_q   <= '0;
      rowCnt_q   <= '0;
      cfgErr_q   <= 1'b0;
      westPrev_q <= '0;
      winData_q  <= '0;
      winValid_q <= 1'b0;
      winLast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      numCols_q  <= numCols_d;
      numRows_q  <= numRows_d;
      colCnt_q   <= colCnt_d;
      rowCnt_q   <= rowCnt_d;
      cfgErr_q   <= cfgErr_d;
      westPrev_q <= westPrev_d;
      winData_q  <= winData_d;
      winValid_q <= winValid_d;
      winLast_q  <= winLast_d;
    end
  end

  // The outgoing centre word ages into lineB as the new sample takes its place.
  always_ff @(posedge aclk) begin
    if (lineWrite) begin
      lineA[addr] <= s_axis_temp_data;
      lineB[addr] <= ctrVal;
    end
  end

  assign m_axis_window_data  = winData_q;
  assign m_axis_window_valid = winValid_q;
  assign m_axis_window_last  = winLast_q;
  assign cfg_error           = cfgErr_q;

`ifdef HOTSPOT_STENCIL_FRAME_COUNT_EN
  logic [31:0] frameCnt_q;

  always_ff @(posedge aclk) begin
    if (axi_reset) begin
      frameCnt_q <= '0;
    end else if (winValid_q && winLast_q && m_axis_window_ready) begin
      frameCnt_q <= frameCnt_q + 32'd1;
    end
  end

  assign frame_count = frameCnt_q;
`else
  assign frame_count = '0;
`endif

endmodule
